// File: rtl/npu_output_drain.sv
// npu_output_drain: drains a job of 32-bit words from the NPU output interface through a 2-deep skid buffer to a valid/ready host port. Ports: CLK/npu_rst clock and async reset; npu_drain_len/_write_en start a job; npu_output_fifo_empty/_interface_dout/_read_en upstream side; host_ready/valid/data/last downstream side; npu_drain_busy/done status.
module npu_output_drain #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             npu_rst,
  input  logic [CNT_W-1:0] npu_drain_len,
  input  logic             npu_drain_len_write_en,
  input  logic             npu_output_fifo_empty,
  input  logic [31:0]      npu_output_interface_dout,
  output logic             npu_output_fifo_read_en,
  input  logic             host_ready,
  output logic             host_valid,
  output logic [31:0]      host_data,
  output logic             host_last,
  output logic             npu_drain_busy,
  output logic             npu_drain_done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] req_left, send_left;
  logic [31:0]      mem [2];
  logic             wr_ptr, rd_ptr, in_flight;
  logic [1:0]       occ;
  logic             pop, start, last_pop;
  assign pop = host_valid & host_ready;
  assign start = (state == IDLE) & npu_drain_len_write_en & (npu_drain_len != '0);
  assign last_pop = pop & (send_left == CNT_W'(1));
  assign host_valid = occ != 2'd0;
  assign host_data = mem[rd_ptr];
  assign host_last = host_valid & (send_left == CNT_W'(1));
  assign npu_drain_busy = state == RUN;
  // A read is only issued if its returning word is guaranteed a buffer slot,
  // counting the word already in flight and the one leaving this cycle.
  always_comb begin
    state_nxt = start ? RUN : last_pop ? IDLE : state;
    npu_output_fifo_read_en = (state == RUN) & !npu_output_fifo_empty & (req_left != '0) &
                              (({1'b0, occ} + {2'b0, in_flight} - {2'b0, pop}) < 3'd2);
  end
  always_ff @(posedge CLK or posedge npu_rst) begin
    if (npu_rst) begin
      state <= IDLE;
      req_left <= '0;
      send_left <= '0;
      in_flight <= 1'b0;
      occ <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
      npu_drain_done <= 1'b0;
    end else begin
      state <= state_nxt;
      in_flight <= npu_output_fifo_read_en;
      npu_drain_done <= last_pop;
      if (start) begin
        req_left <= npu_drain_len;
        send_left <= npu_drain_len;
      end else begin
        if (npu_output_fifo_read_en) req_left <= req_left - CNT_W'(1);
        if (pop) send_left <= send_left - CNT_W'(1);
      end
      if (in_flight) begin
        mem[wr_ptr] <= npu_output_interface_dout;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, in_flight} - {1'b0, pop};
    end
  end
endmodule
